dcache: RTL and testbench

//  Direct-mapped, write-back, write-allocate L1 data cache between the MEM stage and the memory Arbiter.
//  The core side is a single 64-bit word request/done port.
//  The memory side moves whole 64-byte lines via a request/ack/done handshake on the Arbiter's D port.
//  One request is outstanding at a time; the MEM stage stalls the pipeline until done.

---
 rtl/dcache_if.sv | 27 ++
 rtl/dcache.sv | 180 ++++++++++++++++++
 tb/tb_dcache.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_if.sv
// Bus bundle for dcache: the core word port plus the Arbiter line port.
// Both sides use request/complete: enable/drequest is held until done/dreqack; ddone ends a line transfer.
interface dcache_if;
    logic         enable;
    logic         wenable;
    logic [63:0]  addr;
    logic [63:0]  wdata;
    logic [63:0]  rdata;
    logic         done;
    logic         drequest;
    logic         dreqack;
    logic         dwrenable;
    logic [63:0]  daddr;
    logic [511:0] drdata;
    logic [511:0] dwdata;
    logic         ddone;

    modport slave (
        input  enable, wenable, addr, wdata, dreqack, drdata, ddone,
        output rdata, done, drequest, dwrenable, daddr, dwdata
    );

    modport master (
        output enable, wenable, addr, wdata, dreqack, drdata, ddone,
        input  rdata, done, drequest, dwrenable, daddr, dwdata
    );
endinterface

// File: rtl/dcache.sv
// Direct-mapped, write-back, write-allocate L1 data cache with 64-byte lines.
// One core request at a time; misses write back a dirty victim, then fill, then replay as a hit.
module dcache #(
    parameter int SETS = 64
) (
    input  logic       clk,
    input  logic       reset,
    dcache_if.slave    bus,
    output logic [2:0] o_dbg_state
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 64 - 6 - IDX_W;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_RESP      = 3'd1;
    localparam logic [2:0] S_WB_REQ    = 3'd2;
    localparam logic [2:0] S_WB_WAIT   = 3'd3;
    localparam logic [2:0] S_FILL_REQ  = 3'd4;
    localparam logic [2:0] S_FILL_WAIT = 3'd5;
    localparam logic [2:0] S_REFILL    = 3'd6;

    logic [511:0]     r_data [SETS];
    logic [TAG_W-1:0] r_tag  [SETS];
    logic [SETS-1:0]  r_valid;
    logic [SETS-1:0]  r_dirty;

    logic [2:0]   r_state;
    logic [63:3]  r_addr;
    logic         r_we;
    logic [63:0]  r_wdata;
    logic [63:0]  r_rdata;
    logic         r_done;
    logic         r_drequest;
    logic         r_dwrenable;
    logic [63:0]  r_daddr;
    logic [511:0] r_dwdata;

    logic [63:3]      w_req_addr;
    logic             w_req_we;
    logic [63:0]      w_req_wdata;
    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic [2:0]       w_word;
    logic             w_hit;
    logic [63:0]      w_word_old;
    logic [63:0]      w_fill_addr;
    logic             w_lookup;
    logic             w_store;
    logic             w_fill;
    logic             w_wb_done;
    logic             w_unused_addr;

    // In IDLE the live core request is looked up; afterwards the latched copy drives everything,
    // so the miss completes even if the core drops enable.
    always_comb begin
        w_req_addr  = r_addr;
        w_req_we    = r_we;
        w_req_wdata = r_wdata;
        if (r_state == S_IDLE) begin
            w_req_addr  = bus.addr[63:3];
            w_req_we    = bus.wenable;
            w_req_wdata = bus.wdata;
        end
    end

    assign w_idx         = w_req_addr[6 +: IDX_W];
    assign w_tag         = w_req_addr[63 -: TAG_W];
    assign w_word        = w_req_addr[5:3];
    assign w_hit         = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_word_old    = r_data[w_idx][{w_word, 6'b0} +: 64];
    assign w_fill_addr   = {w_req_addr[63:6], 6'b0};
    assign w_unused_addr = ^bus.addr[2:0];

    assign w_lookup  = reset && (((r_state == S_IDLE) && bus.enable && w_hit) ||
                                 (r_state == S_REFILL));
    assign w_store   = w_lookup && w_req_we;
    assign w_fill    = reset && (((r_state == S_FILL_REQ) && bus.dreqack && bus.ddone) ||
                                 ((r_state == S_FILL_WAIT) && bus.ddone));
    assign w_wb_done = ((r_state == S_WB_REQ) && bus.dreqack && bus.ddone) ||
                       ((r_state == S_WB_WAIT) && bus.ddone);

    // Data and tag arrays carry no reset; the valid bits make their contents irrelevant.
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_data[w_idx] <= bus.drdata;
            r_tag[w_idx]  <= w_tag;
        end
        if (w_store) begin
            r_data[w_idx][{w_word, 6'b0} +: 64] <= w_req_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_valid     <= '0;
            r_dirty     <= '0;
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_done      <= 1'b0;
            r_drequest  <= 1'b0;
            r_dwrenable <= 1'b0;
            r_daddr     <= '0;
            r_dwdata    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.enable) begin
                        r_addr  <= bus.addr[63:3];
                        r_we    <= bus.wenable;
                        r_wdata <= bus.wdata;
                        if (w_hit) begin
                            r_done  <= 1'b1;
                            r_state <= S_RESP;
                        end else if (r_valid[w_idx] && r_dirty[w_idx]) begin
                            r_daddr     <= {r_tag[w_idx], w_idx, 6'b0};
                            r_dwdata    <= r_data[w_idx];
                            r_dwrenable <= 1'b1;
                            r_drequest  <= 1'b1;
                            r_state     <= S_WB_REQ;
                        end else begin
                            r_daddr     <= w_fill_addr;
                            r_dwrenable <= 1'b0;
                            r_drequest  <= 1'b1;
                            r_state     <= S_FILL_REQ;
                        end
                    end
                end
                S_WB_REQ: begin
                    if (bus.dreqack) begin
                        r_drequest <= 1'b0;
                        r_state    <= S_WB_WAIT;
                    end
                end
                S_WB_WAIT: ;
                S_FILL_REQ: begin
                    if (bus.dreqack) begin
                        r_drequest <= 1'b0;
                        r_state    <= bus.ddone ? S_REFILL : S_FILL_WAIT;
                    end
                end
                S_FILL_WAIT: begin
                    if (bus.ddone) r_state <= S_REFILL;
                end
                S_REFILL: begin
                    r_done  <= 1'b1;
                    r_state <= S_RESP;
                end
                S_RESP: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase

            // A finished write-back (ack and ddone may coincide) chains straight into the fill.
            if (w_wb_done) begin
                r_dirty[w_idx] <= 1'b0;
                r_daddr        <= w_fill_addr;
                r_dwrenable    <= 1'b0;
                r_drequest     <= 1'b1;
                r_state        <= S_FILL_REQ;
            end
            if (w_fill) begin
                r_valid[w_idx] <= 1'b1;
                r_dirty[w_idx] <= 1'b0;
            end
            if (w_lookup && !w_req_we) r_rdata <= w_word_old;
            if (w_store) r_dirty[w_idx] <= 1'b1;
        end
    end

    assign bus.rdata     = r_rdata;
    assign bus.done      = r_done;
    assign bus.drequest  = r_drequest;
    assign bus.dwrenable = r_dwrenable;
    assign bus.daddr     = r_daddr;
    assign bus.dwdata    = r_dwdata;
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_dcache.sv
// Directed bench for dcache: core driver, Arbiter/memory responder and a done-side scoreboard.
module tb_dcache;
    logic       clk;
    logic       reset;
    logic [2:0] dbg_state;

    dcache_if bus ();

    dcache #(.SETS(64)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    int checks = 0;
    int errors = 0;
    int ack_dly = 1;
    int done_dly = 1;
    int n_req = 0;

    logic [63:0]  exp_q[$];
    logic [64:0]  exp_mem_q[$];
    logic [511:0] exp_wb_q[$];
    logic [511:0] mem [logic [63:0]];

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [511:0] pat(input logic [63:0] a);
        logic [511:0] l;
        for (int i = 0; i < 64; i++) l[8*i +: 8] = 8'(i) + (a[13] ? 8'h40 : 8'h00);
        return l;
    endfunction

    function automatic logic [511:0] mem_rd(input logic [63:0] a);
        if (mem.exists(a)) return mem[a];
        return pat(a);
    endfunction

    // Arbiter / memory responder
    initial begin : arbiter
        logic [64:0]  e;
        logic [511:0] ew;
        logic [63:0]  a;
        logic         we;
        logic [511:0] wd;
        bus.dreqack = 1'b0;
        bus.ddone   = 1'b0;
        bus.drdata  = '0;
        forever begin
            @(negedge clk);
            if (bus.drequest === 1'b1 && reset) begin
                a  = bus.daddr;
                we = bus.dwrenable;
                wd = bus.dwdata;
                n_req++;
                if (exp_mem_q.size() == 0) begin
                    chk("mem_unexpected_req", a, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = exp_mem_q.pop_front();
                    chk("mem_dwrenable", {63'b0, we}, {63'b0, e[64]});
                    chk("mem_daddr", a, e[63:0]);
                end
                if (we) begin
                    checks++;
                    if (exp_wb_q.size() == 0) begin
                        errors++;
                        $display("FAIL wb_unexpected: got %h expected none", wd[191:128]);
                    end else begin
                        ew = exp_wb_q.pop_front();
                        if (wd !== ew) begin
                            errors++;
                            $display("FAIL wb_dwdata: got %h expected %h", wd, ew);
                        end
                    end
                end
                for (int i = 0; i < ack_dly; i++) begin
                    @(negedge clk);
                    chk("req_hold_drequest", {63'b0, bus.drequest}, 64'd1);
                    chk("req_hold_daddr", bus.daddr, a);
                end
                bus.dreqack = 1'b1;
                if (done_dly == 0) begin
                    bus.ddone  = 1'b1;
                    bus.drdata = we ? '0 : mem_rd(a);
                    if (we) mem[a] = wd;
                end
                @(negedge clk);
                bus.dreqack = 1'b0;
                bus.ddone   = 1'b0;
                if (done_dly > 0) begin
                    repeat (done_dly - 1) @(negedge clk);
                    bus.ddone  = 1'b1;
                    bus.drdata = we ? '0 : mem_rd(a);
                    if (we) mem[a] = wd;
                    @(negedge clk);
                    bus.ddone = 1'b0;
                end
            end
        end
    end

    // scoreboard monitor on the done side
    initial begin : monitor
        logic prev_done;
        logic [63:0] e;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                chk("done_single_pulse", {63'b0, prev_done}, 64'd0);
                if (exp_q.size() == 0) begin
                    chk("done_unexpected", bus.rdata, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("rdata", bus.rdata, e);
                end
            end
            prev_done = (bus.done === 1'b1);
        end
    end

    // core driver: pushes the expected rdata, holds enable until done
    task automatic do_req(input logic we, input logic [63:0] a, input logic [63:0] wd,
                          input logic [63:0] exp_rd, output int lat);
        exp_q.push_back(exp_rd);
        @(negedge clk);
        bus.enable  = 1'b1;
        bus.wenable = we;
        bus.addr    = a;
        bus.wdata   = wd;
        lat = 0;
        while (1) begin
            @(negedge clk);
            lat++;
            if (bus.done === 1'b1) break;
            if (lat >= 400) begin
                chk("done_timeout", 64'(lat), 64'd0);
                break;
            end
        end
        bus.enable = 1'b0;
    endtask

    initial begin : main
        int lat;
        int nr;
        logic [511:0] wb1;
        logic [511:0] wb2;
        bus.enable  = 1'b0;
        bus.wenable = 1'b0;
        bus.addr    = '0;
        bus.wdata   = '0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_done", {63'b0, bus.done}, 64'd0);
        chk("rst_drequest", {63'b0, bus.drequest}, 64'd0);
        chk("rst_dwrenable", {63'b0, bus.dwrenable}, 64'd0);
        chk("rst_daddr", bus.daddr, 64'd0);
        chk("rst_dwdata_lo", bus.dwdata[63:0], 64'd0);
        chk("rst_rdata", bus.rdata, 64'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // cold load
        ack_dly = 1; done_dly = 3;
        exp_mem_q.push_back({1'b0, 64'h1000});
        do_req(1'b0, 64'h1000, 64'd0, 64'h0706050403020100, lat);

        // hit load, one-cycle latency, no line traffic
        nr = n_req;
        do_req(1'b0, 64'h1008, 64'd0, 64'h0F0E0D0C0B0A0908, lat);
        chk("hit_load_latency", 64'(lat), 64'd1);
        do_req(1'b1, 64'h1010, 64'hDEADBEEFCAFEF00D, 64'h0F0E0D0C0B0A0908, lat);
        chk("hit_store_latency", 64'(lat), 64'd1);
        do_req(1'b0, 64'h1010, 64'd0, 64'hDEADBEEFCAFEF00D, lat);
        chk("hit_reload_latency", 64'(lat), 64'd1);
        chk("hits_no_drequest", 64'(n_req - nr), 64'd0);

        // conflict miss with dirty victim
        wb1 = pat(64'h1000);
        wb1[191:128] = 64'hDEADBEEFCAFEF00D;
        ack_dly = 2; done_dly = 4;
        exp_mem_q.push_back({1'b1, 64'h1000});
        exp_wb_q.push_back(wb1);
        exp_mem_q.push_back({1'b0, 64'h2000});
        do_req(1'b0, 64'h2010, 64'd0, 64'h5756555453525150, lat);

        // slow Arbiter, clean victim
        ack_dly = 5; done_dly = 10;
        exp_mem_q.push_back({1'b0, 64'h3000});
        do_req(1'b0, 64'h3008, 64'd0, 64'h4F4E4D4C4B4A4948, lat);

        // store miss refetches the written-back line and merges
        ack_dly = 1; done_dly = 1;
        exp_mem_q.push_back({1'b0, 64'h1000});
        do_req(1'b1, 64'h1018, 64'h1122334455667788, 64'h4F4E4D4C4B4A4948, lat);
        do_req(1'b0, 64'h1010, 64'd0, 64'hDEADBEEFCAFEF00D, lat);
        do_req(1'b0, 64'h1018, 64'd0, 64'h1122334455667788, lat);

        // dreqack and ddone in the same cycle for both write-back and fill
        wb2 = wb1;
        wb2[255:192] = 64'h1122334455667788;
        ack_dly = 0; done_dly = 0;
        exp_mem_q.push_back({1'b1, 64'h1000});
        exp_wb_q.push_back(wb2);
        exp_mem_q.push_back({1'b0, 64'h2000});
        do_req(1'b0, 64'h2000, 64'd0, 64'h4746454443424140, lat);

        // reset during FILL_WAIT
        ack_dly = 0; done_dly = 10;
        exp_mem_q.push_back({1'b0, 64'h4000});
        @(negedge clk);
        bus.enable  = 1'b1;
        bus.wenable = 1'b0;
        bus.addr    = 64'h4000;
        lat = 0;
        while (dbg_state !== 3'd5 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("reached_fill_wait", {61'b0, dbg_state}, 64'd5);
        #2 reset = 1'b0;
        #1;
        chk("abort_drequest", {63'b0, bus.drequest}, 64'd0);
        chk("abort_done", {63'b0, bus.done}, 64'd0);
        chk("abort_state_idle", {61'b0, dbg_state}, 64'd0);
        bus.enable = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_rdata_cleared", bus.rdata, 64'd0);
        ack_dly = 0; done_dly = 2;
        nr = n_req;
        exp_mem_q.push_back({1'b0, 64'h4000});
        do_req(1'b0, 64'h4000, 64'd0, 64'h0706050403020100, lat);
        chk("reload_after_reset_misses", 64'(n_req - nr), 64'd1);

        repeat (5) @(negedge clk);
        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
        chk("exp_mem_q_drained", 64'(exp_mem_q.size()), 64'd0);
        chk("exp_wb_q_drained", 64'(exp_wb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end
endmodule
